scc_wave_sched: RTL and testbench

SCC_WAVE_SCHED -- requirements
Module: scc_wave_sched

---
 rtl/scc_wave_sched_if.sv | 31 +++
 rtl/scc_wave_sched.sv | 144 ++++++++++++++
 tb/tb_scc_wave_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scc_wave_sched_if.sv
// rtl/scc_wave_sched_if.sv - CPU, loader, pointer and wave-RAM signal bundle for scc_wave_sched
interface scc_wave_sched_if;
  logic        CpuReq;
  logic        CpuWr;
  logic [7:0]  CpuAdr;
  logic [7:0]  CpuDat;
  logic        LdReq;
  logic [7:0]  LdAdr;
  logic [7:0]  LdDat;
  logic [24:0] PtrBus;
  logic [7:0]  RamAdr;
  logic [7:0]  RamDin;
  logic        RamWe;
  logic [1:0]  RamSel;
  logic        MixEna;
  logic [2:0]  MixCh;
  logic        LdAck;
  logic        FrameStb;
  logic [4:0]  MissMask;
  logic [7:0]  MissCnt;

  modport master (
    output CpuReq, CpuWr, CpuAdr, CpuDat, LdReq, LdAdr, LdDat, PtrBus,
    input  RamAdr, RamDin, RamWe, RamSel, MixEna, MixCh, LdAck, FrameStb, MissMask, MissCnt
  );

  modport slave (
    input  CpuReq, CpuWr, CpuAdr, CpuDat, LdReq, LdAdr, LdDat, PtrBus,
    output RamAdr, RamDin, RamWe, RamSel, MixEna, MixCh, LdAck, FrameStb, MissMask, MissCnt
  );
endinterface

// File: rtl/scc_wave_sched.sv
// rtl/scc_wave_sched.sv - wave-RAM slot scheduler: CPU, five playback channels, preset loader
module scc_wave_sched (
  input logic             pSltClk_n,
  input logic             pSltRst,
  scc_wave_sched_if.slave bus
);
  typedef enum logic [1:0] {
    SEL_IDLE = 2'b00,
    SEL_CPU  = 2'b01,
    SEL_LD   = 2'b10,
    SEL_PLAY = 2'b11
  } sel_e;

  logic [2:0] slot_q, slot_d;
  logic [4:0] pend_q, pend_d;
  logic [4:0] eff_pend, left_pend, clr_mask;
  logic [7:0] adr_q, adr_d, din_q, din_d;
  logic       we_q, we_d, ack_q, ack_d;
  logic       mix_ena_q, mix_ena_d;
  logic [2:0] mix_ch_q, mix_ch_d;
  sel_e       sel_q, sel_d, gnt;
  logic [2:0] play_ch;
  logic       play_hit;
  logic [4:0] ptr;
  logic [4:0] mask_q, mask_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_sum;
  logic [2:0] miss_ones;

  assign eff_pend = (slot_q == 3'd0) ? 5'b11111 : pend_q;

  always_comb begin
    play_ch  = 3'd0;
    play_hit = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (eff_pend[i]) begin
        play_ch  = 3'(i);
        play_hit = 1'b1;
      end
    end
  end

  always_comb begin
    case (play_ch)
      3'd0:    ptr = bus.PtrBus[4:0];
      3'd1:    ptr = bus.PtrBus[9:5];
      3'd2:    ptr = bus.PtrBus[14:10];
      3'd3:    ptr = bus.PtrBus[19:15];
      default: ptr = bus.PtrBus[24:20];
    endcase
  end

  // The loader is skipped while its ack is showing: LdReq is still high that cycle.
  always_comb begin
    gnt      = SEL_IDLE;
    clr_mask = 5'b00000;
    if (bus.CpuReq) begin
      gnt = SEL_CPU;
    end else if (play_hit) begin
      gnt      = SEL_PLAY;
      clr_mask = 5'b00001 << play_ch;
    end else if (bus.LdReq && !ack_q) begin
      gnt = SEL_LD;
    end
  end

  always_comb begin
    adr_d     = adr_q;
    din_d     = din_q;
    we_d      = 1'b0;
    ack_d     = 1'b0;
    sel_d     = gnt;
    mix_ena_d = (sel_q == SEL_PLAY);
    mix_ch_d  = adr_q[7:5];
    case (gnt)
      SEL_CPU: begin
        adr_d = bus.CpuAdr;
        din_d = bus.CpuDat;
        we_d  = bus.CpuWr;
      end
      SEL_PLAY: adr_d = {play_ch, ptr};
      SEL_LD: begin
        adr_d = bus.LdAdr;
        din_d = bus.LdDat;
        we_d  = 1'b1;
        ack_d = 1'b1;
      end
      default: ;
    endcase

    left_pend = eff_pend & ~clr_mask;
    miss_ones = {2'b00, left_pend[0]} + {2'b00, left_pend[1]} + {2'b00, left_pend[2]}
              + {2'b00, left_pend[3]} + {2'b00, left_pend[4]};
    cnt_sum   = {1'b0, cnt_q} + {6'b000000, miss_ones};
    slot_d    = slot_q + 3'd1;
    pend_d    = left_pend;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    if (slot_q == 3'd7) begin
      pend_d = 5'b00000;
      mask_d = left_pend;
      cnt_d  = cnt_sum[8] ? 8'hff : cnt_sum[7:0];
    end
  end

  always_ff @(posedge pSltClk_n) begin
    if (pSltRst) begin
      slot_q    <= 3'd0;
      pend_q    <= 5'b00000;
      adr_q     <= 8'h00;
      din_q     <= 8'h00;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      sel_q     <= SEL_IDLE;
      mix_ena_q <= 1'b0;
      mix_ch_q  <= 3'd0;
      mask_q    <= 5'b00000;
      cnt_q     <= 8'h00;
    end else begin
      slot_q    <= slot_d;
      pend_q    <= pend_d;
      adr_q     <= adr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      ack_q     <= ack_d;
      sel_q     <= sel_d;
      mix_ena_q <= mix_ena_d;
      mix_ch_q  <= mix_ch_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.RamAdr   = adr_q;
  assign bus.RamDin   = din_q;
  assign bus.RamWe    = we_q;
  assign bus.RamSel   = sel_q;
  assign bus.MixEna   = mix_ena_q;
  assign bus.MixCh    = mix_ch_q;
  assign bus.LdAck    = ack_q;
  assign bus.FrameStb = (slot_q == 3'd0) && !pSltRst;
  assign bus.MissMask = mask_q;
  assign bus.MissCnt  = cnt_q;
endmodule

// File: tb/tb_scc_wave_sched.sv
// tb/tb_scc_wave_sched.sv - scoreboard bench for scc_wave_sched
module tb_scc_wave_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scc_wave_sched_if bus ();
  scc_wave_sched dut (.pSltClk_n(clk), .pSltRst(rst), .bus(bus));

  typedef struct packed {
    logic [1:0] sel;
    logic       we;
    logic [7:0] adr;
    logic [7:0] din;
    logic       ack;
    logic       mena;
    logic [2:0] mch;
    logic [4:0] mask;
    logic [7:0] cnt;
    logic       stb;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int         m_slot;
  logic [4:0] m_pend, m_mask;
  logic [7:0] m_adr, m_din, m_cnt;
  logic [1:0] m_sel;
  logic       m_ack;

  logic [7:0] exp44 [5] = '{8'h01, 8'h22, 8'h43, 8'h64, 8'h85};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = 0; m_pend = '0; m_mask = '0; m_adr = '0; m_din = '0;
    m_cnt = '0; m_sel = '0; m_ack = 1'b0;
    sb_q.delete();
  endtask

  task automatic cpu_noise();
    bus.CpuReq = 1'b0;
    bus.CpuWr  = 1'($urandom);
    bus.CpuAdr = 8'($urandom);
    bus.CpuDat = 8'($urandom);
  endtask

  task automatic cpu_req(input logic wr, input logic [7:0] adr, input logic [7:0] dat);
    bus.CpuReq = 1'b1;
    bus.CpuWr  = wr;
    bus.CpuAdr = adr;
    bus.CpuDat = dat;
  endtask

  // One clock: predict this cycle's outcome, push it, clock, pop and compare.
  task automatic cyc();
    exp_t       e;
    logic [4:0] eff, left;
    int         ch, sum;
    eff    = (m_slot == 0) ? 5'h1f : m_pend;
    e      = '0;
    e.mena = (m_sel == 2'b11);
    e.mch  = m_adr[7:5];
    left   = eff;
    ch     = -1;
    for (int i = 0; i < 5; i++) if (ch < 0 && eff[i]) ch = i;
    if (bus.CpuReq) begin
      e.sel = 2'b01; m_adr = bus.CpuAdr; m_din = bus.CpuDat; e.we = bus.CpuWr;
    end else if (ch >= 0) begin
      e.sel = 2'b11; m_adr = {ch[2:0], bus.PtrBus[ch*5 +: 5]}; left[ch] = 1'b0;
    end else if (bus.LdReq && !m_ack) begin
      e.sel = 2'b10; m_adr = bus.LdAdr; m_din = bus.LdDat; e.we = 1'b1; e.ack = 1'b1;
    end
    e.adr = m_adr;
    e.din = m_din;
    if (m_slot == 7) begin
      m_mask = left;
      sum    = int'(m_cnt) + $countones(left);
      m_cnt  = (sum > 255) ? 8'hff : 8'(sum);
      m_pend = '0;
    end else begin
      m_pend = left;
    end
    e.mask = m_mask;
    e.cnt  = m_cnt;
    m_sel  = e.sel;
    m_ack  = e.ack;
    m_slot = (m_slot + 1) % 8;
    e.stb  = (m_slot == 0);
    sb_q.push_back(e);

    @(posedge clk); #1;
    e = sb_q.pop_front();
    check("sel",  bus.RamSel,   e.sel);
    check("we",   bus.RamWe,    e.we);
    check("adr",  bus.RamAdr,   e.adr);
    check("din",  bus.RamDin,   e.din);
    check("ack",  bus.LdAck,    e.ack);
    check("mena", bus.MixEna,   e.mena);
    check("mch",  bus.MixCh,    e.mch);
    check("mask", bus.MissMask, e.mask);
    check("cnt",  bus.MissCnt,  e.cnt);
    check("stb",  bus.FrameStb, e.stb);
    if (bus.LdAck) bus.LdReq = 1'b0;
  endtask

  task automatic align0();
    for (int k = 0; k < 8 && m_slot != 0; k++) begin
      cpu_noise();
      cyc();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("rst_adr",  bus.RamAdr,   0);
      check("rst_din",  bus.RamDin,   0);
      check("rst_we",   bus.RamWe,    0);
      check("rst_sel",  bus.RamSel,   0);
      check("rst_mena", bus.MixEna,   0);
      check("rst_mch",  bus.MixCh,    0);
      check("rst_ack",  bus.LdAck,    0);
      check("rst_stb",  bus.FrameStb, 0);
      check("rst_mask", bus.MissMask, 0);
      check("rst_cnt",  bus.MissCnt,  0);
    end
    rst = 1'b0;
    model_reset();
    #1;
    check("rel_stb", bus.FrameStb, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    cpu_noise();
    bus.LdReq  = 1'b0;
    bus.LdAdr  = 8'h00;
    bus.LdDat  = 8'h00;
    bus.PtrBus = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    model_reset();
    do_reset(3);

    // Idle bus: one playback read per channel in slots 0..4
    for (int i = 0; i < 16; i++) begin
      cpu_noise();
      cyc();
      if (i < 5) check("s44_adr", bus.RamAdr, exp44[i]);
      if (i >= 1 && i <= 5) begin
        check("s44_mena", bus.MixEna, 1);
        check("s44_mch",  bus.MixCh,  32'(i - 1));
      end
    end
    check("s44_cnt", bus.MissCnt, 0);

    // CPU write preempts slot 1; B..E shift to slots 2..5
    align0();
    for (int s = 0; s < 8; s++) begin
      if (s == 1) cpu_req(1'b1, 8'h90, 8'h5A);
      else cpu_noise();
      cyc();
      if (s == 1) begin
        check("s45_we",  bus.RamWe,  1);
        check("s45_adr", bus.RamAdr, 8'h90);
        check("s45_din", bus.RamDin, 8'h5A);
      end
      if (s >= 2 && s <= 5) check("s45_play", bus.RamAdr, exp44[s - 1]);
    end
    check("s45_mask", bus.MissMask, 0);

    // Loader waits for the channels, then gets slot 5 with a single ack
    align0();
    bus.LdReq = 1'b1; bus.LdAdr = 8'h9F; bus.LdDat = 8'hC3;
    acks = 0;
    for (int s = 0; s < 8; s++) begin
      cpu_noise();
      cyc();
      if (bus.LdAck) acks++;
      if (s == 5) begin
        check("s47_sel", bus.RamSel, 2'b10);
        check("s47_we",  bus.RamWe,  1);
        check("s47_adr", bus.RamAdr, 8'h9F);
        check("s47_din", bus.RamDin, 8'hC3);
        check("s47_ack", bus.LdAck,  1);
      end
    end
    check("s47_acks", acks, 1);

    // Same load with a CPU read in slot 5 pushes it to slot 6
    align0();
    bus.LdReq = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s == 5) cpu_req(1'b0, 8'h11, 8'h22);
      else cpu_noise();
      cyc();
      if (s == 5) begin
        check("s47c_ack", bus.LdAck,  0);
        check("s47c_sel", bus.RamSel, 2'b01);
      end
      if (s == 6) begin
        check("s47c_ack6", bus.LdAck,  1);
        check("s47c_adr6", bus.RamAdr, 8'h9F);
      end
    end

    // Reset in slot 3 with B..E still pending
    align0();
    cpu_noise(); cyc();
    cpu_req(1'b0, 8'h33, 8'h00); cyc();
    cpu_req(1'b0, 8'h44, 8'h00); cyc();
    cpu_noise();
    do_reset(2);
    check("s48_cnt", bus.MissCnt, 0);
    for (int s = 0; s < 8; s++) begin
      cpu_noise();
      cyc();
    end
    check("s48_mask", bus.MissMask, 0);
    check("s48_cnt2", bus.MissCnt,  0);

    // CPU hogs every slot: all channels dropped, counter saturates
    align0();
    for (int f = 0; f < 52; f++) begin
      for (int s = 0; s < 8; s++) begin
        cpu_req(1'($urandom), 8'($urandom), 8'($urandom));
        cyc();
      end
      if (f == 0) begin
        check("s46_mask", bus.MissMask, 5'h1f);
        check("s46_cnt1", bus.MissCnt,  5);
      end
      if (f == 49) check("s46_cnt50", bus.MissCnt, 250);
      if (f == 50) check("s46_cnt51", bus.MissCnt, 255);
      if (f == 51) check("s46_sat",   bus.MissCnt, 255);
    end
    for (int s = 0; s < 8; s++) begin
      cpu_noise();
      cyc();
    end
    check("s46_mask0", bus.MissMask, 0);
    check("s46_hold",  bus.MissCnt,  255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
